y_fetch: RTL
============

Y_FETCH -- requirements
Module: y_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value held in reset and IDLE.
REQ-002 Parameter INT_VECTOR, default 32'h0000_0080: handler address loaded on interrupt entry.
REQ-003 Port clk  in  1: single clock; all state updates on rising edge.
REQ-004 Port rst  in  1: asynchronous, active-high reset.
REQ-005 Port entryPoint  in  32: start address, sampled when start=1.
REQ-006 Port start  in  1: one-cycle pulse; loads PC from entryPoint and enters RUN.
REQ-007 Port INT  in  1: interrupt request; rising edge latched as pending.
REQ-008 Port stall  in  1: downstream hold; freezes PC, ins, pc_out and valid.
REQ-009 Port br_taken  in  1: redirect request from the execute stage.
REQ-010 Port br_target  in  32: redirect address, valid with br_taken.
REQ-011 Port imem_addr  out  32: instruction-memory address, equal to the PC.
REQ-012 Port imem_data  in  32: combinational instruction-memory read data for imem_addr.
REQ-013 Port ins  out  32: registered instruction to the chip datapath.
REQ-014 Port pc_out  out  32: address of ins.
REQ-015 Port PCp4  out  32: pc_out + 4, mod 2^32.
REQ-016 Port valid  out  1: ins is a real instruction; 0 = bubble.
REQ-017 Port int_ack  out  1: one-cycle pulse in the interrupt-entry cycle.

Function
REQ-018 States SHALL be IDLE, RUN and INT_ENTRY; reset enters IDLE.
REQ-019 IDLE: PC holds, valid=0; start moves PC to entryPoint and the state to RUN.
REQ-020 RUN, stall=0: ins<=imem_data, pc_out<=PC, valid<=1 and PC<=PC+4, giving 1-cycle fetch latency.
REQ-021 RUN, stall=1: all registers hold; a pending interrupt or redirect is deferred until stall=0.
REQ-022 br_taken=1 with stall=0: PC<=br_target and valid<=0 next cycle, flushing the wrong-path fetch.
REQ-023 Priority, highest first: rst, start, interrupt, br_taken, sequential.
REQ-024 Interrupt taken when pending=1 in RUN with stall=0: state->INT_ENTRY, pending cleared, valid<=0.
REQ-025 INT_ENTRY lasts one cycle: int_ack=1, PC<=INT_VECTOR, then back to RUN.
REQ-026 An INT edge during INT_ENTRY or stall SHALL remain pending and never be lost; further edges while pending are merged.
REQ-027 Interrupt coincident with br_taken: the interrupt wins; the return address is br_target.
REQ-028 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 start while in RUN restarts at entryPoint, clearing valid and pending.

Reset
REQ-030 rst asynchronously forces PC=RESET_PC, ins=0, pc_out=RESET_PC, valid=0, int_ack=0, pending=0, state=IDLE.
REQ-031 rst asserted mid-fetch or mid-INT_ENTRY SHALL abandon the operation with no partial update after release.

Configuration
REQ-032 Macro Y_FETCH_EPC_EN, when defined, adds port epc (out 32), port mret (in 1) and flag in_handler.
REQ-033 With Y_FETCH_EPC_EN, interrupt entry captures epc and sets in_handler.
REQ-034 epc = br_target if redirecting, else the PC that would have been fetched next.
REQ-035 With Y_FETCH_EPC_EN, pending interrupts are held while in_handler=1.
REQ-036 With Y_FETCH_EPC_EN, mret=1 (stall=0) sets PC<=epc, clears in_handler and sets valid<=0; mret outranks br_taken.
REQ-037 Y_FETCH_EPC_EN reset values: epc=0, in_handler=0.
REQ-038 Without Y_FETCH_EPC_EN: no epc or mret ports and no masking, so nested entry is permitted.

Structure
REQ-039 Shared package y_pkg holds the state enum, XLEN=32, the default INT_VECTOR and the instruction width.
REQ-040 A single sub-module, y_pc_next, SHALL compute the next-PC mux combinationally from the priority rules.

Verification
REQ-041 Scenario: reset, start with entryPoint=32'h100, no stall -> imem_addr 100,104,108; ins valid one cycle later with pc_out=100.
REQ-042 Scenario: br_taken=1, br_target=32'h200 at pc_out=108 -> next cycle valid=0, imem_addr=200; following cycle pc_out=200, valid=1.
REQ-043 Scenario: INT edge with stall=1 for 3 cycles -> no ack during stall; int_ack one cycle after stall drops, then imem_addr=80.
REQ-044 Scenario (EPC_EN): INT at PC=10C then mret -> epc=10C, second INT is held until mret, fetch resumes at 10C.
REQ-045 Scenario: rst pulse during INT_ENTRY -> state IDLE, valid=0, pending=0 immediately without waiting for a clock.
REQ-046 Scenario: start at entryPoint=32'hFFFF_FFFC -> second fetch address is 32'h0000_0000.

Source files
------------

// File: rtl/y_pkg.sv
// Shared definitions for the y_fetch instruction-fetch stage: datapath
// widths, the default interrupt vector, the FSM state type and the
// per-cycle action chosen by the next-PC priority logic.
package y_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] INT_VECTOR_DEFAULT = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_INT_ENTRY = 2'd2
    } state_t;

    // What the fetch stage does on the coming clock edge.
    typedef enum logic [2:0] {
        ACT_HOLD     = 3'd0,   // nothing moves (IDLE or stalled)
        ACT_START    = 3'd1,   // (re)start at entryPoint
        ACT_TAKE_INT = 3'd2,   // accept pending interrupt, go to INT_ENTRY
        ACT_VECTOR   = 3'd3,   // INT_ENTRY: jump to handler
        ACT_MRET     = 3'd4,   // return from handler to saved epc
        ACT_REDIRECT = 3'd5,   // execute-stage branch redirect
        ACT_SEQ      = 3'd6    // normal sequential fetch
    } act_t;

    // Sequential successor address, wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/y_pc_next.sv
// Next-PC selection for y_fetch. Resolves the priority
// start > interrupt > mret > br_taken > sequential and reports which
// action won so the top-level FSM can update its registers to match.
module y_pc_next
    import y_pkg::*;
#(
    parameter logic [XLEN-1:0] INT_VECTOR = INT_VECTOR_DEFAULT
)
(
    input  state_t            state_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              start_i,
    input  logic [XLEN-1:0]   entry_point_i,
    input  logic              stall_i,
    input  logic              pending_i,
    input  logic              masked_i,
    input  logic              mret_i,
    input  logic [XLEN-1:0]   epc_i,
    input  logic              br_taken_i,
    input  logic [XLEN-1:0]   br_target_i,
    output act_t              act_o,
    output logic [XLEN-1:0]   pc_next_o
);

    // Priority mux: start overrides everything, INT_ENTRY always completes
    // in one cycle, and RUN only acts when the downstream is not stalled.
    always_comb begin
        act_o     = ACT_HOLD;
        pc_next_o = pc_i;
        if (start_i) begin
            act_o     = ACT_START;
            pc_next_o = entry_point_i;
        end else begin
            case (state_i)
                ST_INT_ENTRY: begin
                    act_o     = ACT_VECTOR;
                    pc_next_o = INT_VECTOR;
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        if (pending_i && !masked_i) begin
                            // PC holds; the wrong fetch is squashed and
                            // the vector is loaded in INT_ENTRY.
                            act_o     = ACT_TAKE_INT;
                            pc_next_o = pc_i;
                        end else if (mret_i) begin
                            act_o     = ACT_MRET;
                            pc_next_o = epc_i;
                        end else if (br_taken_i) begin
                            act_o     = ACT_REDIRECT;
                            pc_next_o = br_target_i;
                        end else begin
                            act_o     = ACT_SEQ;
                            pc_next_o = pc_plus4(pc_i);
                        end
                    end
                end
                default: begin
                    act_o     = ACT_HOLD;
                    pc_next_o = pc_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/y_fetch.sv
// y_fetch: single-issue instruction-fetch stage with 1-cycle fetch
// latency, stall hold, branch redirect and edge-triggered interrupt entry.
// Optional macro Y_FETCH_EPC_EN adds a saved return address (epc), an
// mret input and masking of interrupts while inside the handler.
module y_fetch
    import y_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] INT_VECTOR = INT_VECTOR_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   entryPoint,
    input  logic              start,
    input  logic              INT,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [XLEN-1:0]   br_target,
    output logic [XLEN-1:0]   imem_addr,
    input  logic [ILEN-1:0]   imem_data,
    output logic [ILEN-1:0]   ins,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   PCp4,
    output logic              valid,
    output logic              int_ack
`ifdef Y_FETCH_EPC_EN
    ,
    output logic [XLEN-1:0]   epc,
    input  logic              mret
`endif
);

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [ILEN-1:0]   ins_q;
    logic [XLEN-1:0]   pc_out_q;
    logic              valid_q;
    logic              int_ack_q;
    logic              pending_q;
    logic              int_prev_q;

    act_t              act_d;
    logic [XLEN-1:0]   pc_d;
    logic              int_rise;
    logic              int_masked;
    logic              mret_req;
    logic [XLEN-1:0]   epc_val;

    assign int_rise = INT & ~int_prev_q;

`ifdef Y_FETCH_EPC_EN
    logic [XLEN-1:0]   epc_q;
    logic              in_handler_q;

    assign int_masked = in_handler_q;
    assign mret_req   = mret;
    assign epc_val    = epc_q;
    assign epc        = epc_q;
`else
    // Without the EPC option there is no return path and no masking,
    // so an interrupt may re-enter the handler immediately.
    assign int_masked = 1'b0;
    assign mret_req   = 1'b0;
    assign epc_val    = '0;
`endif

    y_pc_next #(
        .INT_VECTOR    (INT_VECTOR)
    ) u_pc_next (
        .state_i       (state_q),
        .pc_i          (pc_q),
        .start_i       (start),
        .entry_point_i (entryPoint),
        .stall_i       (stall),
        .pending_i     (pending_q),
        .masked_i      (int_masked),
        .mret_i        (mret_req),
        .epc_i         (epc_val),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .act_o         (act_d),
        .pc_next_o     (pc_d)
    );

    // Fetch FSM and output registers, all updated from the chosen action.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ins_q        <= '0;
            pc_out_q     <= RESET_PC;
            valid_q      <= 1'b0;
            int_ack_q    <= 1'b0;
            pending_q    <= 1'b0;
            int_prev_q   <= 1'b0;
`ifdef Y_FETCH_EPC_EN
            epc_q        <= '0;
            in_handler_q <= 1'b0;
`endif
        end else begin
            int_prev_q <= INT;
            int_ack_q  <= 1'b0;
            pc_q       <= pc_d;
            // Edges arriving while stalled, in INT_ENTRY or while masked
            // accumulate here; repeated edges simply merge.
            pending_q  <= pending_q | int_rise;
            case (act_d)
                ACT_START: begin
                    state_q      <= ST_RUN;
                    valid_q      <= 1'b0;
                    pending_q    <= 1'b0;
`ifdef Y_FETCH_EPC_EN
                    in_handler_q <= 1'b0;
`endif
                end
                ACT_TAKE_INT: begin
                    state_q      <= ST_INT_ENTRY;
                    valid_q      <= 1'b0;
                    pending_q    <= 1'b0;
                    int_ack_q    <= 1'b1;
`ifdef Y_FETCH_EPC_EN
                    // Resume where fetch would have gone had no interrupt come.
                    epc_q        <= br_taken ? br_target : pc_q;
                    in_handler_q <= 1'b1;
`endif
                end
                ACT_VECTOR: begin
                    state_q <= ST_RUN;
                    valid_q <= 1'b0;
                end
                ACT_MRET: begin
                    valid_q      <= 1'b0;
`ifdef Y_FETCH_EPC_EN
                    in_handler_q <= 1'b0;
`endif
                end
                ACT_REDIRECT: begin
                    valid_q <= 1'b0;
                end
                ACT_SEQ: begin
                    ins_q    <= imem_data;
                    pc_out_q <= pc_q;
                    valid_q  <= 1'b1;
                end
                default: begin
                    valid_q <= valid_q;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign pc_out    = pc_out_q;
    assign PCp4      = pc_plus4(pc_out_q);
    assign valid     = valid_q;
    assign int_ack   = int_ack_q;

endmodule
